// File: rtl/dram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data-memory block RAM.
// Define DRAM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with port 0 first.
module dram_arbiter #(
  parameter int DEPTH_WORDS = 4096,
  parameter int MAX_LOCK    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  ba0,
  input  logic [1:0]  ba1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_write,
  output logic [1:0]  mem_ba,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int          CW         = $clog2(MAX_LOCK + 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    BA_WORD  = 2'b00,
    BA_BYTE  = 2'b01,
    BA_HALF  = 2'b10,
    BA_WORD3 = 2'b11
  } ba_e;

  logic          lock_active, lock_next;
  logic [CW-1:0] lock_cnt, cnt_next, cnt_inc;
  logic          any_gnt, acc_err, sel_we;
  logic [31:0]   hold0, hold1;
`ifdef DRAM_ARB_RR_EN
  logic          rr_last;
`endif

  function automatic logic access_err(input logic [1:0] ba, input logic [31:0] addr);
    logic misaligned;
    case (ba_e'(ba))
      BA_BYTE: misaligned = 1'b0;
      BA_HALF: misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
    return misaligned || ({1'b0, addr} >= ADDR_LIMIT);
  endfunction

  // A live lock pre-empts the normal policy until its grant budget is spent.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_active && req1 && (lock_cnt < CW'(MAX_LOCK))) gnt1 = 1'b1;
`ifdef DRAM_ARB_RR_EN
    else if (req0 && req1) begin
      if (rr_last) gnt0 = 1'b1;
      else         gnt1 = 1'b1;
    end
`endif
    else if (req0) gnt0 = 1'b1;
    else if (req1) gnt1 = 1'b1;
  end

  always_comb begin
    sel_we    = 1'b0;
    mem_ba    = 2'b00;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (gnt0) begin
      sel_we = we0; mem_ba = ba0; mem_addr = addr0; mem_wdata = wdata0;
    end else if (gnt1) begin
      sel_we = we1; mem_ba = ba1; mem_addr = addr1; mem_wdata = wdata1;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign acc_err   = any_gnt && access_err(mem_ba, mem_addr);
  assign mem_write = sel_we & any_gnt & ~acc_err;

  // Reaching the budget releases the lock and restarts the count from zero.
  always_comb begin
    lock_next = 1'b0;
    cnt_next  = '0;
    cnt_inc   = lock_cnt + CW'(1);
    if (gnt1 && lock1 && (cnt_inc < CW'(MAX_LOCK))) begin
      lock_next = 1'b1;
      cnt_next  = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      hold0       <= 32'd0;
      hold1       <= 32'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      lock_active <= lock_next;
      lock_cnt    <= cnt_next;
      rvalid0     <= gnt0 && !sel_we && !acc_err;
      rvalid1     <= gnt1 && !sel_we && !acc_err;
      err0        <= gnt0 && acc_err;
      err1        <= gnt1 && acc_err;
      if (rvalid0) hold0 <= mem_rdata;
      if (rvalid1) hold1 <= mem_rdata;
    end
  end

`ifdef DRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_last <= 1'b0;
    else if (any_gnt) rr_last <= gnt1;
  end
`endif

  // RAM data is only present in the rvalid cycle, so it bypasses the hold register then.
  assign rdata0 = rvalid0 ? mem_rdata : hold0;
  assign rdata1 = rvalid1 ? mem_rdata : hold1;

endmodule
